pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register. It is the successor to the plain enabled 64-bit register.
- Holds up to two WIDTH-bit words in a main slot and a skid slot.
- in_ready is driven from state flops only, so backpressure from out_ready never reaches the upstream stage combinationally.
- Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); flush supports branch squash.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_reg_en_reg.sv | 20 ++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_stage_reg_en_reg.sv
// WIDTH-bit enabled register with asynchronous active-low reset to RESET_VAL.
module en_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) handshaked pipeline stage; in_ready comes from state flops only.
// Define PIPE_STAGE_PERF_EN to add the stall_cycles output counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles
`endif
);

    stage_state_t     state, state_nxt;
    logic             in_fire, out_fire;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Flush only redirects state; the data slots keep whatever they held.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en   = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en   = 1'b1;
                        state_nxt = ST_TWO;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_en   = 1'b1;
                        main_d    = skid_q;
                        state_nxt = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif

    handshake_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_valid, out_ready}));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand sequences and a FIFO scoreboard.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cycles;
`endif

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic [1:0]   occ;
    } vec_t;

    vec_t         tbl[21];
    logic [W-1:0] sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    longint       stall_m = 0;

    function automatic vec_t mk(logic iv, logic [W-1:0] id, logic ordy, logic fl, logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.occ = occ;
        return v;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare against the scoreboard, update it, cross the edge.
    task automatic step(logic iv, logic [W-1:0] id, logic ordy, logic fl);
        int sz;
        logic of, inf;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz = sb.size();
        chk("out_valid", W'(out_valid), W'(sz > 0));
        chk("in_ready", W'(in_ready), W'(sz < 2));
        chk("occupancy", W'(occupancy), W'(sz));
        if (sz > 0) chk("out_data", out_data, sb[0]);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cycles", W'(stall_cycles), W'(stall_m));
`endif
        of  = (sz > 0) && ordy;
        inf = iv && (sz < 2);
        if (sz > 0 && !ordy) stall_m++;
        if (of) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (inf) sb.push_back(id);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_out_valid"}, W'(out_valid), W'(0));
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        chk({tag, "_occupancy"}, W'(occupancy), W'(0));
        chk({tag, "_out_data"}, out_data, W'(0));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, "_stall"}, W'(stall_cycles), W'(0));
`endif
    endtask

    task automatic do_reset(logic iv, logic [W-1:0] d);
        reset     = 1'b0;
        in_valid  = iv;
        in_data   = d;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        reset_checks("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            reset_checks("rst_hold");
        end
        reset = 1'b1;
        sb.delete();
        stall_m = 0;
        #1;
        reset_checks("rst_release");
    endtask

    initial begin
        tbl[0]  = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);
        tbl[1]  = mk(1'b1, 64'd1,  1'b1, 1'b0, 2'd1);
        tbl[2]  = mk(1'b1, 64'd2,  1'b1, 1'b0, 2'd1);
        tbl[3]  = mk(1'b1, 64'd3,  1'b1, 1'b0, 2'd1);
        tbl[4]  = mk(1'b1, 64'd4,  1'b1, 1'b0, 2'd1);
        tbl[5]  = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);
        tbl[6]  = mk(1'b1, 64'd5,  1'b0, 1'b0, 2'd1);
        tbl[7]  = mk(1'b1, 64'd6,  1'b0, 1'b0, 2'd2);
        tbl[8]  = mk(1'b1, 64'd99, 1'b0, 1'b0, 2'd2);
        tbl[9]  = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd1);
        tbl[10] = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);
        tbl[11] = mk(1'b1, 64'd7,  1'b0, 1'b0, 2'd1);
        tbl[12] = mk(1'b1, 64'd8,  1'b1, 1'b0, 2'd1);
        tbl[13] = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);
        tbl[14] = mk(1'b1, 64'd9,  1'b0, 1'b0, 2'd1);
        tbl[15] = mk(1'b1, 64'd10, 1'b0, 1'b0, 2'd2);
        tbl[16] = mk(1'b1, 64'd11, 1'b0, 1'b1, 2'd0);
        tbl[17] = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);
        tbl[18] = mk(1'b1, 64'd12, 1'b0, 1'b0, 2'd1);
        tbl[19] = mk(1'b1, 64'd13, 1'b1, 1'b1, 2'd0);
        tbl[20] = mk(1'b0, 64'd0,  1'b1, 1'b0, 2'd0);

        // Reset held with a word offered; the first edge after release captures it.
        do_reset(1'b1, 64'hAA);
        step(1'b1, 64'hAA, 1'b0, 1'b0);
        chk("post_reset_capture_occ", W'(occupancy), W'(1));
        chk("post_reset_capture_data", out_data, 64'hAA);

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d_occ", i), W'(occupancy), W'(tbl[i].occ));
        end

        // Reset arriving mid-transfer drops both held words.
        step(1'b1, 64'hC1, 1'b0, 1'b0);
        step(1'b1, 64'hC2, 1'b0, 1'b0);
        chk("pre_midreset_occ", W'(occupancy), W'(2));
        do_reset(1'b1, 64'hC3);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(1)), {$urandom, $urandom},
                 ($urandom_range(3) != 0), ($urandom_range(15) == 0));

`ifdef PIPE_STAGE_PERF_EN
        do_reset(1'b0, 64'd0);
        step(1'b1, 64'h55, 1'b0, 1'b0);
        repeat (5) step(1'b0, 64'd0, 1'b0, 1'b0);
        chk("perf_stall5", W'(stall_cycles), W'(5));
        step(1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("perf_after_flush", W'(stall_cycles), W'(5));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
